// File: rtl/led_strand_pkg.sv
// Shared state encoding, word size and default 100 MHz timing for the WS2812 strand driver.
package led_strand_pkg;

  typedef enum logic [1:0] {
    LATCH,
    REQUEST,
    WAIT_COLOR,
    SHIFT
  } strandState_e;

  localparam int COLOR_BITS = 24;

  localparam int DEFAULT_NUM_LEDS            = 50;
  localparam int DEFAULT_LED_ADDRESS_WIDTH   = 6;
  localparam int DEFAULT_BIT_PERIOD_CYCLES   = 125;
  localparam int DEFAULT_T0H_CYCLES          = 40;
  localparam int DEFAULT_T1H_CYCLES          = 80;
  localparam int DEFAULT_RESET_CYCLES        = 30000;
  localparam int DEFAULT_COLOR_SETTLE_CYCLES = 2;

  // Cycle counters carry one spare bit so the terminal value never wraps.
  function automatic int cntWidth(input int maxCycles);
    return $clog2(maxCycles) + 1;
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Generates one WS2812 bit waveform per start pulse: high for T0H/T1H cycles, low for
// the rest of the period. A start on the final period cycle chains bits with no gap.
module ws2812_bit_timer
  import led_strand_pkg::*;
#(
  parameter int BIT_PERIOD_CYCLES = DEFAULT_BIT_PERIOD_CYCLES,
  parameter int T0H_CYCLES        = DEFAULT_T0H_CYCLES,
  parameter int T1H_CYCLES        = DEFAULT_T1H_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic bitValue_i,
  output logic high_o,
  output logic bitDone_o
);

  localparam int CNT_W = cntWidth(BIT_PERIOD_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] T0H_LEN  = CNT_W'(T0H_CYCLES);
  localparam logic [CNT_W-1:0] T1H_LEN  = CNT_W'(T1H_CYCLES);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] highLen_q, highLen_d;
  logic             high_q, high_d;
  logic [CNT_W-1:0] cntNext;

  assign cntNext = cnt_q + 1'b1;

  // high_q is computed one cycle ahead so the pin is a clean flop output.
  always_comb begin
    active_d  = active_q;
    cnt_d     = cnt_q;
    highLen_d = highLen_q;
    high_d    = high_q;
    if (start_i) begin
      active_d  = 1'b1;
      cnt_d     = '0;
      highLen_d = bitValue_i ? T1H_LEN : T0H_LEN;
      high_d    = 1'b1;
    end else if (active_q) begin
      if (cnt_q == LAST_CNT) begin
        active_d = 1'b0;
        cnt_d    = '0;
        high_d   = 1'b0;
      end else begin
        cnt_d  = cntNext;
        high_d = (cntNext < highLen_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= 1'b0;
      cnt_q     <= '0;
      highLen_q <= '0;
      high_q    <= 1'b0;
    end else begin
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      highLen_q <= highLen_d;
      high_q    <= high_d;
    end
  end

  assign high_o    = high_q;
  assign bitDone_o = active_q && (cnt_q == LAST_CNT);

endmodule

// File: rtl/led_strand_driver.sv
// Walks LED addresses, captures each returned GRB colour and serialises it onto a
// WS2812 data line, closing every frame with a low latch gap.
module led_strand_driver
  import led_strand_pkg::*;
#(
  parameter int NUM_LEDS            = DEFAULT_NUM_LEDS,
  parameter int LED_ADDRESS_WIDTH   = DEFAULT_LED_ADDRESS_WIDTH,
  parameter int BIT_PERIOD_CYCLES   = DEFAULT_BIT_PERIOD_CYCLES,
  parameter int T0H_CYCLES          = DEFAULT_T0H_CYCLES,
  parameter int T1H_CYCLES          = DEFAULT_T1H_CYCLES,
  parameter int RESET_CYCLES        = DEFAULT_RESET_CYCLES,
  parameter int COLOR_SETTLE_CYCLES = DEFAULT_COLOR_SETTLE_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 green_in,
  input  logic [7:0]                 red_in,
  input  logic [7:0]                 blue_in,
  input  logic                       color_valid,
  output logic [LED_ADDRESS_WIDTH:0] next_led_request,
  output logic                       strand_out,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int ADDR_W   = LED_ADDRESS_WIDTH + 1;
  localparam int LATCH_W  = cntWidth(RESET_CYCLES);
  localparam int SETTLE_W = cntWidth(COLOR_SETTLE_CYCLES);
  localparam int BITCNT_W = $clog2(COLOR_BITS);

  localparam logic [LATCH_W-1:0]  LATCH_LAST    = LATCH_W'(RESET_CYCLES - 1);
  localparam logic [LATCH_W-1:0]  LATCH_PRE     = LATCH_W'(RESET_CYCLES - 2);
  localparam logic [SETTLE_W-1:0] SETTLE_TARGET = SETTLE_W'(COLOR_SETTLE_CYCLES);
  localparam logic [ADDR_W-1:0]   LAST_LED      = ADDR_W'(NUM_LEDS - 1);
  localparam logic [BITCNT_W-1:0] FIRST_BIT     = BITCNT_W'(COLOR_BITS - 1);

  if (!(T0H_CYCLES >= 1 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_PERIOD_CYCLES)) begin : gBadBitTiming
    $error("led_strand_driver: need 1 <= T0H_CYCLES < T1H_CYCLES < BIT_PERIOD_CYCLES");
  end
  if (NUM_LEDS < 1 || (2 ** LED_ADDRESS_WIDTH) < NUM_LEDS) begin : gBadLedCount
    $error("led_strand_driver: NUM_LEDS must be >= 1 and fit in LED_ADDRESS_WIDTH");
  end
  if (RESET_CYCLES < 2) begin : gBadLatch
    $error("led_strand_driver: RESET_CYCLES must be at least 2");
  end

  strandState_e         state_q;
  logic [LATCH_W-1:0]   latchCnt_q;
  logic [SETTLE_W-1:0]  settle_q;
  logic [ADDR_W-1:0]    ledIndex_q;
  logic [ADDR_W-1:0]    request_q;
  logic [COLOR_BITS-1:0] shift_q;
  logic [BITCNT_W-1:0]  bitCnt_q;
  logic                 frameDone_q;
  logic                 busy_q;

  logic settled;
  logic captureNow;
  logic nextBit;
  logic startBit;
  logic bitValue;
  logic bitHigh;
  logic bitDone;

  // The first bit starts on the capture edge straight from the inputs, so the
  // shift register only has to supply bits 22..0.
  assign settled    = (settle_q >= SETTLE_TARGET);
  assign captureNow = (state_q == WAIT_COLOR) && settled && color_valid;
  assign nextBit    = (state_q == SHIFT) && bitDone && (bitCnt_q != '0);
  assign startBit   = captureNow || nextBit;
  assign bitValue   = captureNow ? green_in[7] : shift_q[COLOR_BITS-2];

  ws2812_bit_timer #(
    .BIT_PERIOD_CYCLES(BIT_PERIOD_CYCLES),
    .T0H_CYCLES       (T0H_CYCLES),
    .T1H_CYCLES       (T1H_CYCLES)
  ) uBitTimer (
    .clk       (clk),
    .rst       (rst),
    .start_i   (startBit),
    .bitValue_i(bitValue),
    .high_o    (bitHigh),
    .bitDone_o (bitDone)
  );

  // frame_done is raised one count early so the pulse lands on the final latch cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LATCH;
      latchCnt_q  <= '0;
      settle_q    <= '0;
      ledIndex_q  <= '0;
      request_q   <= '0;
      shift_q     <= '0;
      bitCnt_q    <= '0;
      frameDone_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      case (state_q)
        LATCH: begin
          frameDone_q <= (latchCnt_q == LATCH_PRE);
          if (latchCnt_q == LATCH_LAST) begin
            latchCnt_q <= '0;
            ledIndex_q <= '0;
            request_q  <= '0;
            state_q    <= REQUEST;
          end else begin
            latchCnt_q <= latchCnt_q + 1'b1;
          end
        end
        REQUEST: begin
          settle_q <= '0;
          state_q  <= WAIT_COLOR;
        end
        WAIT_COLOR: begin
          if (captureNow) begin
            shift_q  <= {green_in, red_in, blue_in};
            bitCnt_q <= FIRST_BIT;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end else if (!settled) begin
            settle_q <= settle_q + 1'b1;
          end
        end
        SHIFT: begin
          if (bitDone) begin
            if (bitCnt_q != '0) begin
              bitCnt_q <= bitCnt_q - 1'b1;
              shift_q  <= shift_q << 1;
            end else begin
              busy_q <= 1'b0;
              if (ledIndex_q == LAST_LED) begin
                latchCnt_q <= '0;
                request_q  <= '0;
                state_q    <= LATCH;
              end else begin
                ledIndex_q <= ledIndex_q + 1'b1;
                request_q  <= ledIndex_q + 1'b1;
                state_q    <= REQUEST;
              end
            end
          end
        end
        default: state_q <= LATCH;
      endcase
    end
  end

  assign next_led_request = request_q;
  assign strand_out       = bitHigh;
  assign frame_done       = frameDone_q;
  assign busy             = busy_q;

endmodule

// File: doc/led_strand_driver.md
Name: led_strand_driver

Overview:
- Initiator side of the per-LED colour request interface. Walks LED addresses 0..NUM_LEDS-1 on next_led_request and captures the 24-bit colour that the colour source returns for each address.
- Serialises each captured colour onto a single WS2812-style data line, then holds a latch (reset) gap before starting the next frame.
- Sits between any colour source (calibration ID display, pattern generator) and the physical LED strand pin.

Parameters:
- NUM_LEDS, 50, number of LEDs in the strand.
- LED_ADDRESS_WIDTH, 6, width of the LED address; must satisfy 2**LED_ADDRESS_WIDTH >= NUM_LEDS.
- BIT_PERIOD_CYCLES, 125, clk cycles per serial bit (1.25 us at 100 MHz).
- T0H_CYCLES, 40, high time of a 0 bit.
- T1H_CYCLES, 80, high time of a 1 bit.
- RESET_CYCLES, 30000, low latch time between frames (300 us).
- COLOR_SETTLE_CYCLES, 2, minimum cycles between a request change and colour capture.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- green_in  input  8  green component for the current request
- red_in  input  8  red component
- blue_in  input  8  blue component
- color_valid  input  1  colour inputs are valid for the current request
- next_led_request  output  LED_ADDRESS_WIDTH+1  address of the LED whose colour is wanted
- strand_out  output  1  serial data line to the strand
- frame_done  output  1  one-cycle pulse when the latch gap of a frame ends
- busy  output  1  high while shifting pixel bits; low during latch/wait

Behaviour:
- Reset is rst, synchronous, active-high, on clk. While rst is high:
  - strand_out=0, next_led_request=0, frame_done=0, busy=0.
  - Internal state=LATCH, latch counter=0, LED index=0.
- State machine has four states: LATCH, REQUEST, WAIT_COLOR, SHIFT.
- LATCH:
  - strand_out=0 and next_led_request=0.
  - Counts RESET_CYCLES cycles. On the last cycle, frame_done pulses for 1 cycle, then go to REQUEST with LED index=0.
- REQUEST:
  - Drive next_led_request=index. Clear the settle counter, go to WAIT_COLOR.
- WAIT_COLOR:
  - Hold next_led_request. Wait at least COLOR_SETTLE_CYCLES cycles.
  - On the first cycle after that with color_valid=1, capture the shift word {green_in, red_in, blue_in} (GRB order, MSB first) and go to SHIFT.
  - If color_valid stays low, wait indefinitely with strand_out low. No timeout.
- SHIFT:
  - Emits 24 bits, each exactly BIT_PERIOD_CYCLES long.
  - strand_out=1 for the first T0H_CYCLES (bit=0) or T1H_CYCLES (bit=1) of the period, 0 for the remainder.
  - Bit counter runs 23 down to 0. After the final bit period:
    - if index==NUM_LEDS-1, go to LATCH;
    - else index+1 and go to REQUEST.
- Back-to-back pixels: the gap between pixels is REQUEST + WAIT_COLOR cycles with strand_out low. This gap must stay well under the strand's latch threshold; COLOR_SETTLE_CYCLES small guarantees this.
- next_led_request timing:
  - Changes only on entry to REQUEST or LATCH.
  - Is stable through WAIT_COLOR and SHIFT.
  - Returns to 0 for the whole latch, so a source that tracks zero-request transitions sees one per frame.
- Latency: the first rising edge of strand_out for LED 0 occurs COLOR_SETTLE_CYCLES+2 cycles after LATCH exits, given color_valid already high.
- Widths:
  - Cycle counters are sized $clog2(max cycles)+1.
  - The index compare uses the full LED_ADDRESS_WIDTH+1 width.
  - The upper request bit is always 0.
- Colour inputs are ignored outside WAIT_COLOR. Changes during SHIFT do not affect the word being sent.
- rst asserted mid-SHIFT: strand_out goes low on the next edge. Once rst is released, a full latch gap runs before any data, so the strand always sees a clean frame start.
- Elaboration-time checks: T0H_CYCLES < T1H_CYCLES < BIT_PERIOD_CYCLES; NUM_LEDS >= 1.

Decomposition:
- Shared package led_strand_pkg:
  - state enum {LATCH, REQUEST, WAIT_COLOR, SHIFT};
  - COLOR_BITS=24;
  - default timing constants for 100 MHz.
- Sub-module ws2812_bit_timer:
  - Inputs: start, bit value. Outputs: high/low waveform, bit_done pulse.
  - Owns the period counter. The top level owns the FSM, LED index and the 24-bit shift register.

Test Plan (sim parameters NUM_LEDS=3, BIT_PERIOD_CYCLES=10, T0H_CYCLES=3, T1H_CYCLES=7, RESET_CYCLES=20, COLOR_SETTLE_CYCLES=2):
- Reset then release -> strand_out low for 20 cycles; frame_done single pulse; next_led_request=0 throughout the latch.
- Source returns G=0x00,R=0xFF,B=0x00 for all LEDs -> per LED: 8 bits of 3-high/7-low, then 8 bits of 7-high/3-low, then 8 bits of 3-high/7-low; total 240 cycles of bit waveform per LED.
- Requests over one frame -> next_led_request sequence 0,1,2, then 0 held for the latch; frame_done once per frame; second frame is identical.
- color_valid held low 50 cycles after request=1 -> strand_out stays low, request held at 1; data resumes one cycle after color_valid rises.
- Colour inputs toggled mid-SHIFT -> transmitted word equals the value captured at WAIT_COLOR exit.
- rst pulsed during bit 10 of LED 1 -> strand_out low next cycle; after release, a full 20-cycle latch, then LED 0 retransmitted from its first bit.
